// File: rtl/ram_copy_engine_if.sv
// Command and RAM-side bundles for ram_copy_engine.
// FILL/PATTERN exist only when RAM_COPY_FILL_EN is defined.
interface copy_cmd_if #(
`ifdef RAM_COPY_FILL_EN
    parameter int WIDTH    = 32,
`endif
    parameter int ADDRBITS = 12
);
    logic                START;
    logic [ADDRBITS-1:0] SRC;
    logic [ADDRBITS-1:0] DST;
    logic [ADDRBITS:0]   LEN;
    logic                BUSY;
    logic                DONE;
`ifdef RAM_COPY_FILL_EN
    logic                FILL;
    logic [WIDTH-1:0]    PATTERN;

    modport master (output START, SRC, DST, LEN, FILL, PATTERN, input BUSY, DONE);
    modport slave  (input START, SRC, DST, LEN, FILL, PATTERN, output BUSY, DONE);
`else
    modport master (output START, SRC, DST, LEN, input BUSY, DONE);
    modport slave  (input START, SRC, DST, LEN, output BUSY, DONE);
`endif
endinterface

interface copy_ram_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 12
);
    logic                EN1;
    logic                WR1;
    logic [ADDRBITS-1:0] ADDR1;
    logic [WIDTH-1:0]    RD_DATA;
    logic                EN2;
    logic                WR2;
    logic [ADDRBITS-1:0] ADDR2;
    logic [WIDTH-1:0]    DIN2;

    modport master (output EN1, WR1, ADDR1, EN2, WR2, ADDR2, DIN2, input RD_DATA);
    modport slave  (input EN1, WR1, ADDR1, EN2, WR2, ADDR2, DIN2, output RD_DATA);
endinterface

// File: rtl/ram_copy_engine.sv
// Block-copy engine driving both ports of a dual-port RAM, one word per clock.
// Optional fill mode (constant PATTERN instead of reads) under RAM_COPY_FILL_EN.
module ram_copy_engine #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 12
) (
    input  logic       CLK,
    input  logic       RST_N,
    copy_cmd_if.slave  cmd,
    copy_ram_if.master ram
);

    // state | meaning
    // IDLE  | waiting for START, BUSY=0
    // RUN   | issuing reads (writes lag one cycle)
    // DRAIN | last write in flight, EN1=0
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_slot, w_slot_nxt;
    logic                r_en1, w_en1_nxt;
    logic                r_en2, w_en2_nxt;
    logic [ADDRBITS-1:0] r_addr1, w_addr1_nxt;
    logic [ADDRBITS-1:0] r_addr2, w_addr2_nxt;
    logic [ADDRBITS-1:0] r_dst_ptr, w_dst_ptr_nxt;
    logic [ADDRBITS-1:0] r_cnt, w_cnt_nxt;
    logic                w_accept;
    logic                w_fill_nxt;
    logic [WIDTH-1:0]    w_din2;

`ifdef RAM_COPY_FILL_EN
    logic                r_fill;
    logic [WIDTH-1:0]    r_pattern, w_pattern_nxt;
`endif

    assign w_accept = cmd.START && !r_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_slot_nxt    = 1'b0;
        w_addr1_nxt   = r_addr1;
        w_cnt_nxt     = r_cnt;
        // a read slot in this cycle becomes a write slot in the next
        w_en2_nxt     = r_slot;
        w_addr2_nxt   = r_slot ? r_dst_ptr : r_addr2;
        w_dst_ptr_nxt = r_slot ? r_dst_ptr + 1'b1 : r_dst_ptr;
`ifdef RAM_COPY_FILL_EN
        w_fill_nxt    = r_fill;
        w_pattern_nxt = r_pattern;
`else
        w_fill_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_busy_nxt    = 1'b1;
                    w_addr1_nxt   = cmd.SRC;
                    w_dst_ptr_nxt = cmd.DST;
`ifdef RAM_COPY_FILL_EN
                    w_fill_nxt    = cmd.FILL;
                    w_pattern_nxt = cmd.PATTERN;
`endif
                    if (cmd.LEN != '0) begin
                        w_state_nxt = S_RUN;
                        w_slot_nxt  = 1'b1;
                        // full-RAM length has zero low bits and wraps to all ones
                        w_cnt_nxt   = cmd.LEN[ADDRBITS-1:0] - 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt != '0) begin
                    w_slot_nxt  = 1'b1;
                    w_addr1_nxt = r_addr1 + 1'b1;
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
        w_en1_nxt = w_slot_nxt && !w_fill_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_slot    <= 1'b0;
            r_en1     <= 1'b0;
            r_en2     <= 1'b0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_dst_ptr <= '0;
            r_cnt     <= '0;
`ifdef RAM_COPY_FILL_EN
            r_fill    <= 1'b0;
            r_pattern <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_slot    <= w_slot_nxt;
            r_en1     <= w_en1_nxt;
            r_en2     <= w_en2_nxt;
            r_addr1   <= w_addr1_nxt;
            r_addr2   <= w_addr2_nxt;
            r_dst_ptr <= w_dst_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
`ifdef RAM_COPY_FILL_EN
            r_fill    <= w_fill_nxt;
            r_pattern <= w_pattern_nxt;
`endif
        end
    end

`ifdef RAM_COPY_FILL_EN
    assign w_din2 = !r_en2 ? '0 : (r_fill ? r_pattern : ram.RD_DATA);
`else
    assign w_din2 = r_en2 ? ram.RD_DATA : '0;
`endif

    assign cmd.BUSY  = r_busy;
    assign cmd.DONE  = r_done;
    assign ram.EN1   = r_en1;
    assign ram.WR1   = 1'b0;
    assign ram.ADDR1 = r_addr1;
    assign ram.EN2   = r_en2;
    assign ram.WR2   = r_en2;
    assign ram.ADDR2 = r_addr2;
    assign ram.DIN2  = w_din2;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine with a behavioural dual-port RAM.
// Fill-mode stimulus is included when RAM_COPY_FILL_EN is defined.
module tb_ram_copy_engine;
    localparam int WIDTH    = 32;
    localparam int ADDRBITS = 12;
    localparam int N        = 1 << ADDRBITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef RAM_COPY_FILL_EN
    copy_cmd_if #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) cmd ();
`else
    copy_cmd_if #(.ADDRBITS(ADDRBITS)) cmd ();
`endif
    copy_ram_if #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) ram ();

    ram_copy_engine #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .cmd   (cmd.slave),
        .ram   (ram.master)
    );

    typedef struct {
        int               cyc;
        int               addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic [WIDTH-1:0] mem     [N];
    logic [WIDTH-1:0] ref_mem [N];
    exp_t rdq[$];
    exp_t wrq[$];
    int   doneq[$];
    int   cyc       = 0;
    int   busy_from = -1;
    int   busy_to   = -2;
    int   total     = 0;
    int   bad       = 0;
    bit   mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read on port 1, write on port 2
    initial begin
        for (int i = 0; i < N; i++) mem[i] = WIDTH'(i);
        ram.RD_DATA = '0;
        forever begin
            @(posedge clk);
            if (ram.EN1 === 1'b1 && ram.WR1 === 1'b0) ram.RD_DATA <= mem[ram.ADDR1];
            if (ram.EN2 === 1'b1 && ram.WR2 === 1'b1) mem[ram.ADDR2] <= ram.DIN2;
        end
    end

    function automatic logic [ADDRBITS-1:0] wrap(input int x);
        return ADDRBITS'(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", 32'(cmd.BUSY), 32'((cyc >= busy_from) && (cyc <= busy_to)));
            chk("wr1", 32'(ram.WR1), 32'd0);
            if (ram.EN1 === 1'b1) begin
                if (rdq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    e = rdq.pop_front();
                    chk("rd_cyc", 32'(cyc), 32'(e.cyc));
                    chk("rd_addr", 32'(ram.ADDR1), 32'(e.addr));
                end
            end
            if (ram.EN2 === 1'b1) begin
                chk("wr2", 32'(ram.WR2), 32'd1);
                if (wrq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else begin
                    e = wrq.pop_front();
                    chk("wr_cyc", 32'(cyc), 32'(e.cyc));
                    chk("wr_addr", 32'(ram.ADDR2), 32'(e.addr));
                    chk("wr_data", ram.DIN2, e.data);
                end
            end else begin
                chk("idle_din2", ram.DIN2, 32'd0);
                chk("idle_wr2", 32'(ram.WR2), 32'd0);
            end
            if (cmd.DONE === 1'b1) begin
                if (doneq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else chk("done_cyc", 32'(cyc), 32'(doneq.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (cmd.BUSY !== 1'b0) begin
            n++;
            if (n > 6000) begin
                chk("idle_timeout", 32'd1, 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 32'(cmd.BUSY), 32'd0);
        chk({tag, "_done"}, 32'(cmd.DONE), 32'd0);
        chk({tag, "_en1"}, 32'(ram.EN1), 32'd0);
        chk({tag, "_en2"}, 32'(ram.EN2), 32'd0);
        chk({tag, "_wr2"}, 32'(ram.WR2), 32'd0);
        chk({tag, "_addr1"}, 32'(ram.ADDR1), 32'd0);
        chk({tag, "_addr2"}, 32'(ram.ADDR2), 32'd0);
        chk({tag, "_din2"}, ram.DIN2, 32'd0);
    endtask

    // abort_w >= 0: reset lands after that many writes have been committed
    task automatic issue(input int src, input int dst, input int len, input bit hold,
                         input bit fill, input logic [WIDTH-1:0] pat, input int abort_w);
        int a;
        int nrd;
        int nwr;
        logic [WIDTH-1:0] d;
        wait_idle();
        cmd.SRC   = wrap(src);
        cmd.DST   = wrap(dst);
        cmd.LEN   = (ADDRBITS+1)'(len);
`ifdef RAM_COPY_FILL_EN
        cmd.FILL    = fill;
        cmd.PATTERN = pat;
`endif
        cmd.START = 1'b1;
        a   = cyc + 1;
        nrd = (abort_w >= 0) ? abort_w + 1 : len;
        nwr = (abort_w >= 0) ? abort_w : len;
        busy_from = a;
        busy_to   = (abort_w >= 0) ? a + abort_w : a + len;
        for (int k = 0; k < nrd; k++)
            if (!fill) rdq.push_back('{cyc: a + k, addr: (src + k) % N, data: '0});
        for (int k = 0; k < nwr; k++) begin
            d = fill ? pat : ref_mem[wrap(src + k)];
            wrq.push_back('{cyc: a + k + 1, addr: (dst + k) % N, data: d});
            ref_mem[wrap(dst + k)] = d;
        end
        if (abort_w < 0) doneq.push_back(a + len + 1);
        @(negedge clk);
        // inputs change while BUSY; the engine must use its latched copy
        cmd.SRC   = wrap(int'($urandom_range(0, N - 1)));
        cmd.DST   = wrap(int'($urandom_range(0, N - 1)));
        cmd.LEN   = (ADDRBITS+1)'($urandom_range(0, N));
        cmd.START = hold;
    endtask

    initial begin
        int src, dst, len, diff, nbad;
        bit hold;
        for (int i = 0; i < N; i++) ref_mem[i] = WIDTH'(i);
        cmd.START = 1'b0;
        cmd.SRC   = '0;
        cmd.DST   = '0;
        cmd.LEN   = '0;
`ifdef RAM_COPY_FILL_EN
        cmd.FILL    = 1'b0;
        cmd.PATTERN = '0;
`endif
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        issue(12'h010, 12'h100, 4, 1'b0, 1'b0, '0, -1);
        issue(12'h333, 12'h444, 0, 1'b0, 1'b0, '0, -1);
        issue(12'hFFE, 12'h7FF, 4, 1'b0, 1'b0, '0, -1);
        issue(12'h200, 12'h300, 3, 1'b1, 1'b0, '0, -1);
        issue(12'h210, 12'h310, 2, 1'b0, 1'b0, '0, -1);

        for (int i = 0; i < 24; i++) begin
            len = $urandom_range(0, 40);
            src = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) == 0) dst = (src + N - $urandom_range(0, len)) % N;
            else dst = $urandom_range(0, N - 1);
            diff = (dst - src + N) % N;
            while (diff != 0 && diff < len) begin
                dst  = $urandom_range(0, N - 1);
                diff = (dst - src + N) % N;
            end
            hold = (i != 23) && ($urandom_range(0, 1) == 1);
            issue(src, dst, len, hold, 1'b0, '0, -1);
        end

        issue(12'h500, 12'h600, 8, 1'b0, 1'b0, '0, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        rst_n = 1'b1;

        issue(12'h123, 12'h123, N, 1'b0, 1'b0, '0, -1);
`ifdef RAM_COPY_FILL_EN
        issue(12'h000, 12'h020, 3, 1'b0, 1'b1, 32'hDEADCAFE, -1);
        issue(12'h040, 12'h050, 3, 1'b0, 1'b0, '0, -1);
`endif

        wait_idle();
        repeat (4) @(negedge clk);
        chk("rdq_left", 32'(rdq.size()), 32'd0);
        chk("wrq_left", 32'(wrq.size()), 32'd0);
        chk("doneq_left", 32'(doneq.size()), 32'd0);
        nbad = 0;
        for (int i = 0; i < N; i++)
            if (mem[i] !== ref_mem[i]) begin
                if (nbad < 4) $display("FAIL mem[%0h]: got=%0h want=%0h", i, mem[i], ref_mem[i]);
                nbad++;
            end
        chk("mem_image_mismatches", 32'(nbad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
